// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register and divide unit.
// ALU operation codes, FSM state encoding and small op-decode helpers.
// Optional feature macro used by the top: HILO_MULT_EN.
package hilo_div_unit_pkg;

    // ALU operation codes seen in EX
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Divide sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_mult_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

endpackage

// File: rtl/hilo_div_unit_div_radix2.sv
// div_radix2: iterative radix-2 restoring divider core.
// Operates on magnitudes; sign correction is applied to the final
// quotient/remainder, which are presented combinationally on o_quot/o_rem
// during the last iteration (o_done) so the owner can capture them at that edge.
module div_radix2
    import hilo_div_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_cancel,
    input  logic          i_signed,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quot,
    output logic [DW-1:0] o_rem
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_quo;
    logic [DW-1:0]    r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [DW-1:0]    w_a_mag;
    logic [DW-1:0]    w_b_mag;
    logic [DW:0]      w_shift;
    logic             w_fits;
    logic [DW-1:0]    w_rem_nxt;
    logic [DW-1:0]    w_quo_nxt;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude.
    assign w_a_neg = i_signed & i_a[DW-1];
    assign w_b_neg = i_signed & i_b[DW-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits. A carry out of the shift
    // means the partial remainder already exceeds any DW-bit divisor.
    assign w_shift   = {r_rem, r_quo[DW-1]};
    assign w_fits    = w_shift[DW] | (w_shift[DW-1:0] >= r_dvs);
    assign w_rem_nxt = w_fits ? (w_shift[DW-1:0] - r_dvs) : w_shift[DW-1:0];
    assign w_quo_nxt = {r_quo[DW-2:0], w_fits};

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(DW - 1));
    assign o_quot = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign o_rem  = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    // Iteration control: busy flag and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_cancel) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Datapath: load magnitudes on start, then one quotient bit per cycle
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: EX-stage owner of the HI/LO registers.
// Handles MTHI/MTLO/MFHI/MFLO and sequences DIV/DIVU through div_radix2,
// freezing the pipeline via stall_o while a divide is in flight.
// Optional feature: define HILO_MULT_EN to make MULT/MULTU write the
// 64-bit product into {HI,LO} in a single cycle; otherwise they write nothing.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [7:0]    aluop_i,
    input  logic          write_hilo_i,
    input  logic [DW-1:0] srca_i,
    input  logic [DW-1:0] srcb_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic [DW-1:0] hilo_rdata_o,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o
);

    state_t        r_state;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    logic          w_idle;
    logic          w_accept;
    logic          w_div_start;
    logic          w_b_zero;
    logic          w_core_start;
    logic          w_core_busy;
    logic          w_core_done;
    logic [DW-1:0] w_core_quot;
    logic [DW-1:0] w_core_rem;
    logic          w_mthi;
    logic          w_mtlo;
    logic          w_div_write;

    // New instructions are only taken in IDLE; a flushed slot does nothing.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle && en_i && !flush_i;
    assign w_div_start  = w_accept && is_div_op(aluop_i);
    assign w_b_zero     = (srcb_i == '0);
    assign w_core_start = w_div_start && !w_b_zero;
    assign w_mthi       = w_accept && write_hilo_i && (aluop_i == EXE_MTHI_OP);
    assign w_mtlo       = w_accept && write_hilo_i && (aluop_i == EXE_MTLO_OP);

    // A completing divide loses to a flush arriving in the same cycle.
    assign w_div_write  = (r_state == ST_BUSY) && w_core_done && !flush_i;

    // Stall covers the issue cycle and every iteration; a flush releases it
    // immediately.
    assign stall_o = w_div_start || (w_core_busy && !flush_i);

    assign hi_o = r_hi;
    assign lo_o = r_lo;

`ifdef HILO_MULT_EN
    logic          w_mult;
    logic [2*DW-1:0] w_prod;

    assign w_mult = w_accept && write_hilo_i && is_mult_op(aluop_i);

    // Signed product uses sign-extended operands; the low 2*DW bits are exact.
    always_comb begin
        w_prod = '0;
        if (aluop_i == EXE_MULT_OP) begin
            w_prod = {{DW{srca_i[DW-1]}}, srca_i} * {{DW{srcb_i[DW-1]}}, srcb_i};
        end else begin
            w_prod = {{DW{1'b0}}, srca_i} * {{DW{1'b0}}, srcb_i};
        end
    end
`endif

    // Register read mux for MFHI/MFLO
    always_comb begin
        hilo_rdata_o = '0;
        if (aluop_i == EXE_MFHI_OP) begin
            hilo_rdata_o = r_hi;
        end else if (aluop_i == EXE_MFLO_OP) begin
            hilo_rdata_o = r_lo;
        end
    end

    div_radix2 #(
        .DW    (DW),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_core_start),
        .i_cancel (flush_i),
        .i_signed (aluop_i == EXE_DIV_OP),
        .i_a      (srca_i),
        .i_b      (srcb_i),
        .o_busy   (w_core_busy),
        .o_done   (w_core_done),
        .o_quot   (w_core_quot),
        .o_rem    (w_core_rem)
    );

    // Divide sequencer: IDLE -> BUSY -> DONE -> IDLE, zero divisor skips BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_div_start) begin
                        r_state <= w_b_zero ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_core_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The held DIV retires here; it must not start again.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_write) begin
            r_hi <= w_core_rem;
            r_lo <= w_core_quot;
        end else if (w_div_start && w_b_zero) begin
            r_hi <= srca_i;
            r_lo <= '1;
        end else if (w_mthi) begin
            r_hi <= srca_i;
        end else if (w_mtlo) begin
            r_lo <= srca_i;
`ifdef HILO_MULT_EN
        end else if (w_mult) begin
            r_hi <= w_prod[2*DW-1:DW];
            r_lo <= w_prod[DW-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed steps plus randomized
// divides and HI/LO moves, checked against an arithmetic reference model.
// Honours HILO_MULT_EN when deciding what MULT is expected to do.
module tb_hilo_div_unit;
    import hilo_div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic [7:0]  aluop_i;
    logic        write_hilo_i;
    logic [31:0] srca_i;
    logic [31:0] srcb_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hilo_rdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_div_unit #(.DW(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .aluop_i      (aluop_i),
        .write_hilo_i (write_hilo_i),
        .srca_i       (srca_i),
        .srcb_i       (srcb_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .hilo_rdata_o (hilo_rdata_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: {HI,LO} after a divide, from plain integer arithmetic
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic idle_inputs();
        en_i         = 1'b0;
        write_hilo_i = 1'b0;
        aluop_i      = 8'h00;
        flush_i      = 1'b0;
    endtask

    // Issue a divide, count stall cycles (bounded), check latency and result
    task automatic do_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int n;
        aluop_i      = sgn ? EXE_DIV_OP : EXE_DIVU_OP;
        en_i         = 1'b1;
        write_hilo_i = 1'b1;
        srca_i       = a;
        srcb_i       = b;
        flush_i      = 1'b0;
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, " stall_cycles"}, n, (b == 32'd0) ? 1 : 33);
        r = ref_div(sgn, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk({tag, " hi"}, hi_o, exp_hi);
        chk({tag, " lo"}, lo_o, exp_lo);
        idle_inputs();
        tick();
    endtask

    task automatic do_mt(input bit to_hi, input logic [31:0] v);
        aluop_i      = to_hi ? EXE_MTHI_OP : EXE_MTLO_OP;
        en_i         = 1'b1;
        write_hilo_i = 1'b1;
        srca_i       = v;
        #1;
        chk("mt stall", {31'd0, stall_o}, 32'd0);
        tick();
        if (to_hi) exp_hi = v; else exp_lo = v;
        aluop_i      = to_hi ? EXE_MFHI_OP : EXE_MFLO_OP;
        write_hilo_i = 1'b0;
        #1;
        chk(to_hi ? "mfhi rdata" : "mflo rdata", hilo_rdata_o, v);
        chk("mt hi", hi_o, exp_hi);
        chk("mt lo", lo_o, exp_lo);
        idle_inputs();
    endtask

    initial begin
        longint p;
        int mode;
        bit sgn;
        logic [31:0] a, b;

        rst = 1'b1;
        idle_inputs();
        srca_i = '0;
        srcb_i = '0;
        exp_hi = '0;
        exp_lo = '0;
        tick();
        tick();
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        chk("reset rdata", hilo_rdata_o, 32'd0);
        rst = 1'b0;
        tick();

        // HI/LO moves and reads
        do_mt(1'b1, 32'h1234_5678);
        do_mt(1'b0, 32'hCAFE_0001);
        #1;
        chk("rdata non-mf", hilo_rdata_o, 32'd0);

        // Flush in IDLE blocks an MTHI
        aluop_i = EXE_MTHI_OP; en_i = 1'b1; write_hilo_i = 1'b1;
        srca_i = 32'hDEAD_BEEF; flush_i = 1'b1;
        tick();
        idle_inputs();
        chk("flushed mthi hi", hi_o, exp_hi);

        // Divides: basic, signed, overflow wrap, zero divisor
        do_div("divu 100/7", 1'b0, 32'd100, 32'd7);
        chk("divu lo=14", lo_o, 32'd14);
        chk("divu hi=2", hi_o, 32'd2);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 lo", lo_o, 32'hFFFF_FFFD);
        chk("div -7/2 hi", hi_o, 32'hFFFF_FFFF);
        do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div min/-1 lo", lo_o, 32'h8000_0000);
        chk("div min/-1 hi", hi_o, 32'd0);
        do_div("div 5/0", 1'b1, 32'd5, 32'd0);
        chk("div0 hi", hi_o, 32'd5);
        chk("div0 lo", lo_o, 32'hFFFF_FFFF);
        do_div("divu 9/0", 1'b0, 32'd9, 32'd0);
        do_div("div 7/-3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        do_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0001);

        // Flush at T+10 cancels the divide without touching HI/LO
        aluop_i = EXE_DIVU_OP; en_i = 1'b1; write_hilo_i = 1'b1;
        srca_i = 32'd200; srcb_i = 32'd9;
        #1;
        chk("flush10 stall T", {31'd0, stall_o}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1;
        #1;
        chk("flush10 stall drop", {31'd0, stall_o}, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("flush10 hi", hi_o, exp_hi);
        chk("flush10 lo", lo_o, exp_lo);
        chk("flush10 stall after", {31'd0, stall_o}, 32'd0);
        do_div("div after flush", 1'b1, 32'hFFFF_FF00, 32'd16);

        // Flush on the completing cycle wins over the write
        aluop_i = EXE_DIV_OP; en_i = 1'b1; write_hilo_i = 1'b1;
        srca_i = 32'd1000; srcb_i = 32'd3;
        #1;
        for (int i = 0; i < 32; i++) tick();
        chk("flush32 stall", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush32 stall drop", {31'd0, stall_o}, 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("flush32 hi", hi_o, exp_hi);
        chk("flush32 lo", lo_o, exp_lo);
        tick();
        chk("flush32 no late write", lo_o, exp_lo);

        // Reset at T+5 of a divide
        aluop_i = EXE_DIVU_OP; en_i = 1'b1; write_hilo_i = 1'b1;
        srca_i = 32'd1000; srcb_i = 32'd3;
        #1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        #1;
        chk("midrst hi", hi_o, 32'd0);
        chk("midrst lo", lo_o, 32'd0);
        chk("midrst stall", {31'd0, stall_o}, 32'd0);
        tick();
        do_div("div after rst", 1'b0, 32'd77, 32'd5);

        // MULT: product only when the feature is built in
        aluop_i = EXE_MULT_OP; en_i = 1'b1; write_hilo_i = 1'b1;
        srca_i = 32'hFFFF_FFFD; srcb_i = 32'd4;
        #1;
        chk("mult stall", {31'd0, stall_o}, 32'd0);
        tick();
        idle_inputs();
`ifdef HILO_MULT_EN
        p = longint'($signed(32'hFFFF_FFFD)) * 64'sd4;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
`else
        p = 0;
`endif
        chk("mult hi", hi_o, exp_hi);
        chk("mult lo", lo_o, exp_lo);

        // Randomized divides and moves against the model
        for (int i = 0; i < 16; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom & 32'h0000_FFFF | 32'd1;
                default: b = $urandom | 32'd1;
            endcase
            sgn = 1'($urandom_range(0, 1));
            do_div("rand div", sgn, a, b);
            do_mt(1'($urandom_range(0, 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
